// File: rtl/fpu_seq.sv
// Control sequencer for the FPU add/sub/multiply datapath: load, align, ALU op, normalize,
// with multiplies handed off to the multiplier through a start/done handshake.
module fpu_seq #(
  parameter int unsigned MANT_W       = 24,
  parameter int unsigned MULT_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic       signOfMaiorExp,
  input  logic       signOfMenorExp,
  input  logic [7:0] expDiff,
  input  logic       carry_out,
  input  logic       msb,
  input  logic       res_zero,
  input  logic       done_mult,
  output logic       load_regs,
  output logic       align_shift,
  output logic [1:0] ula_cmd,
  output logic       res_load,
  output logic       norm_right,
  output logic       norm_left,
  output logic       start_mult,
  output logic       busy,
  output logic       done,
  output logic       zero_res,
  output logic       error
);

  localparam int unsigned AlignMax = MANT_W + 1;
  localparam int unsigned NormMax  = MANT_W - 1;
  localparam int unsigned CntMax   = (MULT_TIMEOUT > AlignMax) ? MULT_TIMEOUT : AlignMax;
  localparam int unsigned CntW     = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StAlign,
    StOp,
    StNorm,
    StMwait,
    StDone
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            op_sub_q;
  logic            zero_q;
  logic            error_q;

  logic [CntW-1:0] cnt_inc;
  logic [CntW-1:0] align_lim;
  logic            eff_sub;

  assign cnt_inc = cnt_q + CntW'(1);

  // Large exponent differences saturate: MANT_W+1 shifts already flush the smaller mantissa.
  always_comb begin
    align_lim = CntW'(AlignMax);
    if (32'(expDiff) < AlignMax) begin
      align_lim = CntW'(expDiff);
    end
  end

  // Signs come from the swapped operand registers, so they are read live in OP.
  assign eff_sub = (signOfMaiorExp ^ signOfMenorExp) ^ op_sub_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_sub_q <= 1'b0;
      zero_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_sub_q <= (op == 2'b01);
            cnt_q    <= '0;
            zero_q   <= 1'b0;
            error_q  <= 1'b0;
            unique case (op)
              2'b00, 2'b01: state_q <= StLoad;
              2'b10:        state_q <= StMwait;
              default: begin
                error_q <= 1'b1;
                state_q <= StDone;
              end
            endcase
          end
        end
        StLoad: begin
          cnt_q <= '0;
          if (expDiff == 8'd0) begin
            state_q <= StOp;
          end else begin
            state_q <= StAlign;
          end
        end
        StAlign: begin
          cnt_q <= cnt_inc;
          if (cnt_inc == align_lim) begin
            state_q <= StOp;
          end
        end
        StOp: begin
          cnt_q   <= '0;
          state_q <= StNorm;
        end
        StNorm: begin
          if (carry_out) begin
            state_q <= StDone;
          end else if (res_zero) begin
            zero_q  <= 1'b1;
            state_q <= StDone;
          end else if (msb) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CntW'(NormMax)) begin
              state_q <= StDone;
            end
          end
        end
        StMwait: begin
          cnt_q <= cnt_inc;
          if (done_mult) begin
            state_q <= StDone;
          end else if (cnt_inc == CntW'(MULT_TIMEOUT)) begin
            error_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    ula_cmd = 2'b00;
    if (state_q == StOp) begin
      ula_cmd = eff_sub ? 2'b10 : 2'b01;
    end
  end

  assign load_regs   = (state_q == StLoad);
  assign align_shift = (state_q == StAlign);
  assign res_load    = (state_q == StOp);
  assign norm_right  = (state_q == StNorm) && carry_out;
  assign norm_left   = (state_q == StNorm) && !carry_out && !res_zero && !msb;
  assign start_mult  = (state_q == StMwait) && (cnt_q == '0);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign zero_res    = zero_q;
  assign error       = error_q;

endmodule

// File: tb/tb_fpu_seq.sv
// Randomized self-checking bench for fpu_seq: a behavioural datapath emulation drives the status
// inputs and per-operation pulse counts and latencies are checked against arithmetic expectations.
module tb_fpu_seq;

  localparam int unsigned MantW       = 24;
  localparam int unsigned MultTimeout = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] op;
  logic       signOfMaiorExp;
  logic       signOfMenorExp;
  logic [7:0] expDiff;
  logic       carry_out;
  logic       msb;
  logic       res_zero;
  logic       done_mult;
  logic       load_regs;
  logic       align_shift;
  logic [1:0] ula_cmd;
  logic       res_load;
  logic       norm_right;
  logic       norm_left;
  logic       start_mult;
  logic       busy;
  logic       done;
  logic       zero_res;
  logic       error;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  fpu_seq #(
    .MANT_W      (MantW),
    .MULT_TIMEOUT(MultTimeout)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .signOfMaiorExp(signOfMaiorExp),
    .signOfMenorExp(signOfMenorExp),
    .expDiff       (expDiff),
    .carry_out     (carry_out),
    .msb           (msb),
    .res_zero      (res_zero),
    .done_mult     (done_mult),
    .load_regs     (load_regs),
    .align_shift   (align_shift),
    .ula_cmd       (ula_cmd),
    .res_load      (res_load),
    .norm_right    (norm_right),
    .norm_left     (norm_left),
    .start_mult    (start_mult),
    .busy          (busy),
    .done          (done),
    .zero_res      (zero_res),
    .error         (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int unsigned all_outs();
    return {20'd0, load_regs, align_shift, ula_cmd, res_load, norm_right, norm_left,
            start_mult, busy, done, zero_res, error};
  endfunction

  // kind: 0 = normalize until msb after nsh left shifts, 1 = carry, 2 = exact cancellation.
  task automatic run_op(input logic [1:0] o, input logic s1, input logic s2,
                        input int unsigned ed, input int unsigned kind, input int unsigned nsh,
                        input int unsigned kmult, input bit noise, input bit hold);
    int unsigned c = 0, done_c = 0;
    int unsigned na = 0, nu = 0, ula_v = 0, nrl = 0, nl = 0, nr = 0, nsm = 0, smc = 0;
    int unsigned nlow = 0, zr = 0, er = 0;
    int unsigned a, exp_n, exp_done, exp_err;
    bit          eff_sub;

    @(negedge clock);
    op             = o;
    signOfMaiorExp = s1;
    signOfMenorExp = s2;
    expDiff        = ed[7:0];
    carry_out      = (kind == 1);
    res_zero       = (kind == 2);
    msb            = (kind == 0) && (nsh == 0);
    done_mult      = 1'b0;
    start          = 1'b1;
    @(posedge clock);
    while (done_c == 0 && c < 300) begin
      c++;
      #1;
      if (!hold) start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) op = 2'($urandom_range(0, 3));
      msb = (kind == 0) && (nl >= nsh);
      if (o == 2'b10) done_mult = (c >= kmult);
      else done_mult = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (align_shift) na++;
      if (ula_cmd != 2'b00) begin
        nu++;
        ula_v = ula_cmd;
      end
      if (res_load) nrl++;
      if (norm_left) nl++;
      if (norm_right) nr++;
      if (start_mult) begin
        nsm++;
        if (smc == 0) smc = c;
      end
      if (!busy) nlow++;
      if (done) begin
        done_c = c;
        zr     = zero_res;
        er     = error;
      end else begin
        @(posedge clock);
      end
    end
    check("done_seen", (done_c != 0), 1);
    check("busy_during_op", nlow, 0);

    exp_err = 0;
    if (o == 2'b11) begin
      exp_done = 1;
      exp_err  = 1;
    end else if (o == 2'b10) begin
      if (kmult <= MultTimeout) begin
        exp_done = kmult + 1;
      end else begin
        exp_done = MultTimeout + 1;
        exp_err  = 1;
      end
      check("start_mult_pulses", nsm, 1);
      check("start_mult_cycle", smc, 1);
    end else begin
      a       = (ed < MantW + 1) ? ed : MantW + 1;
      eff_sub = (s1 != s2) ^ (o == 2'b01);
      exp_n   = 0;
      if (kind == 0) exp_n = (nsh < MantW - 1) ? nsh : MantW - 1;
      // A flag-terminated normalize spends one extra NORM cycle without shifting.
      if (kind == 0 && nsh >= MantW - 1) exp_done = 3 + a + exp_n;
      else exp_done = 4 + a + exp_n;
      check("align_pulses", na, a);
      check("ula_cycles", nu, 1);
      check("ula_cmd", ula_v, eff_sub ? 2 : 1);
      check("res_load_pulses", nrl, 1);
      check("norm_left_pulses", nl, exp_n);
      check("norm_right_pulses", nr, (kind == 1) ? 1 : 0);
      check("start_mult_pulses", nsm, 0);
    end
    if (o != 2'b00 && o != 2'b01) check("align_pulses", na, 0);
    check("done_cycle", done_c, exp_done);
    check("zero_res", zr, (o[1] == 1'b0 && kind == 2) ? 1 : 0);
    check("error", er, exp_err);

    #1;
    if (hold) begin
      @(posedge clock);
      #2;
      check("held_start_idle", busy, 0);
      @(posedge clock);
      #2;
      check("held_start_reaccept", busy, 1);
      start = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
    end else begin
      start = 1'b0;
      @(posedge clock);
      #2;
      check("idle_after_done", busy, 0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    op             = 2'b00;
    signOfMaiorExp = 1'b0;
    signOfMenorExp = 1'b0;
    expDiff        = 8'd0;
    carry_out      = 1'b0;
    msb            = 1'b0;
    res_zero       = 1'b0;
    done_mult      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_outputs", all_outs(), 0);
    reset = 1'b0;

    // Reset while in the middle of alignment.
    @(negedge clock);
    expDiff = 8'd10;
    msb     = 1'b1;
    start   = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("pre_reset_align", align_shift, 1);
    reset = 1'b1;
    @(posedge clock);
    #2;
    check("mid_align_reset_outputs", all_outs(), 0);
    reset = 1'b0;

    run_op(2'b00, 1'b0, 1'b0, 3, 0, 0, 0, 1'b0, 1'b0);
    run_op(2'b01, 1'b1, 1'b1, 0, 0, 2, 0, 1'b0, 1'b0);
    run_op(2'b00, 1'b0, 1'b1, 0, 2, 0, 0, 1'b0, 1'b0);
    run_op(2'b00, 1'b1, 1'b1, 5, 1, 0, 0, 1'b0, 1'b0);
    run_op(2'b00, 1'b0, 1'b0, 200, 0, 40, 0, 1'b0, 1'b0);
    run_op(2'b01, 1'b0, 1'b0, 25, 0, 22, 0, 1'b0, 1'b0);
    run_op(2'b10, 1'b0, 1'b0, 0, 0, 0, 5, 1'b0, 1'b0);
    run_op(2'b10, 1'b0, 1'b0, 0, 0, 0, 1000, 1'b0, 1'b0);
    run_op(2'b10, 1'b0, 1'b0, 0, 0, 0, MultTimeout, 1'b0, 1'b0);
    run_op(2'b11, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_op(2'b00, 1'b0, 1'b1, 2, 0, 1, 0, 1'b0, 1'b0);
    run_op(2'b00, 1'b0, 1'b0, 1, 0, 0, 0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      int unsigned red;
      ro  = 2'($urandom_range(0, 3));
      red = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 27);
      run_op(ro, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), red,
             $urandom_range(0, 2), $urandom_range(0, 25),
             ($urandom_range(0, 4) == 0) ? 500 : $urandom_range(1, 70), 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
